dcache_write_buffer: RTL and testbench

Write-through store buffer sitting directly downstream of the data-cache memory. Captures each registered store-hit writeback (8-byte line, address, valid pulse), queues it in FIFO order, and drains entries to main memory as `BUS_STORE` requests when the memory arbiter grants the bus. Provides load-miss forwarding from queued entries, plus full and empty status for LSQ stalling and end-of-program drain.

---
 rtl/dcache_write_buffer_pkg.sv | 20 ++
 rtl/wb_fwd_select.sv | 40 ++++
 rtl/dcache_write_buffer.sv | 131 +++++++++++++
 tb/tb_dcache_write_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared system definitions for the data-cache write path: bus command
// encoding, the write-buffer entry record and the default buffer depth.
package dcache_write_buffer_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // One buffered line: address is the 8-byte line number (addr[31:3]).
  typedef struct packed {
    logic        valid;
    logic [28:0] addr;
    logic [63:0] data;
  } WB_ENTRY;

  localparam int unsigned WB_DEPTH = 4;

endpackage

// File: rtl/wb_fwd_select.sv
// Youngest-match selector for load-miss forwarding out of the write buffer.
// Only entries inside the live window [head, tail) are considered; when the
// buffer is full (head == tail with a valid head) the whole array is live.
module wb_fwd_select
  import dcache_write_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  WB_ENTRY [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]    head,
  input  logic [PTR_W-1:0]    tail,
  input  logic [28:0]         cmp_addr,
  output logic                hit,
  output logic [63:0]         data
);

  logic             full;
  logic [PTR_W-1:0] span;
  logic [PTR_W-1:0] idx;

  assign full = (head == tail) && entries[head].valid;
  assign span = tail - head;

  // Walk oldest to youngest so the last live match (closest to tail) wins
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((full || (PTR_W'(k) < span)) && entries[idx].valid &&
          (entries[idx].addr == cmp_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write-through store buffer behind the data cache. Queues store-hit lines
// in FIFO order, drains them as BUS_STORE when granted, forwards queued data
// to load misses and reports stall/empty/overflow status.
// Optional build macro: WB_COALESCE_EN -- a store to a line already queued
// (other than the head) overwrites that entry instead of allocating.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        evict_en,
  input  logic [63:0] evict_data,
  input  logic [31:0] evict_addr,
  input  logic        mem_grant,
  input  logic [3:0]  mem2wb_response,
  output BUS_COMMAND  wb2mem_command,
  output logic [31:0] wb2mem_addr,
  output logic [63:0] wb2mem_data,
  input  logic [31:0] ld_addr,
  output logic        ld_fwd_hit,
  output logic [63:0] ld_fwd_data,
  output logic        wb_stall,
  output logic        wb_empty,
  output logic        wb_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  WB_ENTRY [DEPTH-1:0] entries;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic not_empty;
  logic full;
  logic pop;
  logic enq;
  logic coal_hit;
  logic unused_bits;

  assign not_empty   = (count != '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign unused_bits = ^{evict_addr[2:0], ld_addr[2:0]};

  // Present the head entry; request the bus only while granted
  always_comb begin
    wb2mem_command = BUS_NONE;
    wb2mem_addr    = '0;
    wb2mem_data    = '0;
    if (not_empty) begin
      wb2mem_addr = {entries[head].addr, 3'b000};
      wb2mem_data = entries[head].data;
      if (mem_grant) wb2mem_command = BUS_STORE;
    end
  end

  assign pop = (wb2mem_command == BUS_STORE) && (mem2wb_response != '0);

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;
  logic [PTR_W-1:0] scan_idx;

  // Find the newest non-head entry for the same line; head is skipped so an
  // in-flight pop is never modified underneath the memory
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (evict_en && entries[scan_idx].valid &&
          (entries[scan_idx].addr == evict_addr[31:3])) begin
        coal_hit = 1'b1;
        coal_idx = scan_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  // A full buffer still accepts a store when the head leaves this cycle
  assign enq         = evict_en && !coal_hit && (!full || pop);
  assign wb_overflow = evict_en && !coal_hit && full && !pop;

  // Queue state; enqueue is written after pop so a full-buffer enqueue into
  // the slot being vacated leaves it valid
  always_ff @(posedge clock) begin
    if (reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
`ifdef WB_COALESCE_EN
      if (coal_hit) entries[coal_idx].data <= evict_data;
`endif
      if (enq) begin
        entries[tail] <= '{valid: 1'b1, addr: evict_addr[31:3], data: evict_data};
        tail          <= tail + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wb_stall = (count >= CNT_W'(DEPTH - 1));
  assign wb_empty = !not_empty;

  wb_fwd_select #(
    .DEPTH(DEPTH)
  ) u_fwd (
    .entries (entries),
    .head    (head),
    .tail    (tail),
    .cmp_addr(ld_addr[31:3]),
    .hit     (ld_fwd_hit),
    .data    (ld_fwd_data)
  );

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// queue-based reference model.
module tb_dcache_write_buffer;
  import dcache_write_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam BUS_COMMAND S = BUS_STORE;
  localparam BUS_COMMAND N = BUS_NONE;
`ifdef WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        evict_en;
  logic [63:0] evict_data;
  logic [31:0] evict_addr;
  logic        mem_grant;
  logic [3:0]  mem2wb_response;
  BUS_COMMAND  wb2mem_command;
  logic [31:0] wb2mem_addr;
  logic [63:0] wb2mem_data;
  logic [31:0] ld_addr;
  logic        ld_fwd_hit;
  logic [63:0] ld_fwd_data;
  logic        wb_stall;
  logic        wb_empty;
  logic        wb_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  dcache_write_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .evict_en       (evict_en),
    .evict_data     (evict_data),
    .evict_addr     (evict_addr),
    .mem_grant      (mem_grant),
    .mem2wb_response(mem2wb_response),
    .wb2mem_command (wb2mem_command),
    .wb2mem_addr    (wb2mem_addr),
    .wb2mem_data    (wb2mem_data),
    .ld_addr        (ld_addr),
    .ld_fwd_hit     (ld_fwd_hit),
    .ld_fwd_data    (ld_fwd_data),
    .wb_stall       (wb_stall),
    .wb_empty       (wb_empty),
    .wb_overflow    (wb_overflow)
  );

  typedef struct {
    logic        ev;
    logic [31:0] ea;
    logic [63:0] ed;
    logic        gr;
    logic [3:0]  rsp;
    logic [31:0] la;
  } stim_t;

  typedef struct {
    BUS_COMMAND  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic        empty;
    logic        stall;
    logic        hit;
    logic [63:0] fwd;
    logic        ovf;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  typedef struct {
    logic [28:0] a;
    logic [63:0] d;
  } ment_t;

  // Reference model: the buffer is an ordered list, oldest first
  ment_t mq[$];

  function automatic vec_t V(input logic ev, input logic [31:0] ea, input logic [63:0] ed,
                             input logic gr, input logic [3:0] rsp, input logic [31:0] la,
                             input BUS_COMMAND cmd, input logic [31:0] addr,
                             input logic [63:0] data, input logic em, input logic st,
                             input logic hi, input logic [63:0] fw, input logic ov);
    vec_t v;
    v.s = '{ev: ev, ea: ea, ed: ed, gr: gr, rsp: rsp, la: la};
    v.e = '{cmd: cmd, addr: addr, data: data, empty: em, stall: st, hit: hi, fwd: fw, ovf: ov};
    return v;
  endfunction

  function automatic int m_coal(input logic [28:0] a);
    if (!COALESCE) return -1;
    for (int i = int'(mq.size()) - 1; i >= 1; i--)
      if (mq[i].a == a) return i;
    return -1;
  endfunction

  function automatic obs_t model_obs(input stim_t s);
    obs_t o;
    int   ci;
    bit   pop;
    o.cmd   = (mq.size() != 0 && s.gr) ? BUS_STORE : BUS_NONE;
    o.addr  = (mq.size() != 0) ? {mq[0].a, 3'b000} : 32'h0;
    o.data  = (mq.size() != 0) ? mq[0].d : 64'h0;
    o.empty = (mq.size() == 0);
    o.stall = (mq.size() >= DEPTH - 1);
    o.hit   = 1'b0;
    o.fwd   = 64'h0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].a == s.la[31:3]) begin
        o.hit = 1'b1;
        o.fwd = mq[i].d;
      end
    ci    = s.ev ? m_coal(s.ea[31:3]) : -1;
    pop   = (o.cmd == BUS_STORE) && (s.rsp != 4'd0);
    o.ovf = s.ev && (ci < 0) && (mq.size() == DEPTH) && !pop;
    return o;
  endfunction

  task automatic model_step(input stim_t s);
    obs_t o;
    int   ci;
    o  = model_obs(s);
    ci = s.ev ? m_coal(s.ea[31:3]) : -1;
    if (ci >= 0) mq[ci].d = s.ed;
    if (o.cmd == BUS_STORE && s.rsp != 4'd0) void'(mq.pop_front());
    if (s.ev && ci < 0 && !o.ovf) mq.push_back('{a: s.ea[31:3], d: s.ed});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t e);
    chk({tag, " cmd"},   64'(wb2mem_command), 64'(e.cmd));
    chk({tag, " addr"},  64'(wb2mem_addr),    64'(e.addr));
    chk({tag, " data"},  wb2mem_data,         e.data);
    chk({tag, " empty"}, 64'(wb_empty),       64'(e.empty));
    chk({tag, " stall"}, 64'(wb_stall),       64'(e.stall));
    chk({tag, " hit"},   64'(ld_fwd_hit),     64'(e.hit));
    chk({tag, " fwd"},   ld_fwd_data,         e.fwd);
    chk({tag, " ovf"},   64'(wb_overflow),    64'(e.ovf));
  endtask

  // Drive one cycle, check settled outputs, then clock it
  task automatic run_cycle(input stim_t s, input obs_t e, input bit vs_model, input string tag);
    evict_en        = s.ev;
    evict_addr      = s.ea;
    evict_data      = s.ed;
    mem_grant       = s.gr;
    mem2wb_response = s.rsp;
    ld_addr         = s.la;
    #3;
    if (vs_model) chk_obs(tag, model_obs(s));
    else          chk_obs(tag, e);
    model_step(s);
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    run_cycle(v.s, v.e, 1'b0, tag);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    evict_en        = 1'b0;
    evict_addr      = '0;
    evict_data      = '0;
    mem_grant       = 1'b0;
    mem2wb_response = '0;
    ld_addr         = '0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
  endtask

  vec_t  tbl[$];
  vec_t  idle;
  stim_t rs;
  obs_t  dummy;

  initial begin
    idle = V(L, 32'h0, 64'h0, L, 4'd0, 32'h0, N, 32'h0, 64'h0, H, L, L, 64'h0, L);
    dummy = idle.e;

    // reset state
    tbl.push_back(idle);
    // single store, drained next cycle
    tbl.push_back(V(H, 32'h1000, 64'hDEADBEEF_CAFEF00D, H, 4'd1, 32'h0,    N, 32'h0,    64'h0,                 H, L, L, 64'h0, L));
    tbl.push_back(V(L, 32'h0,    64'h0,                 H, 4'd1, 32'h1000, S, 32'h1000, 64'hDEADBEEF_CAFEF00D, L, L, H, 64'hDEADBEEF_CAFEF00D, L));
    tbl.push_back(V(L, 32'h0,    64'h0,                 L, 4'd0, 32'h1000, N, 32'h0,    64'h0,                 H, L, L, 64'h0, L));
    // three enqueues without grant, stall at count 3, in-order drain
    tbl.push_back(V(H, 32'h100, 64'h11, L, 4'd0, 32'h0, N, 32'h0,   64'h0,  H, L, L, 64'h0, L));
    tbl.push_back(V(H, 32'h108, 64'h22, L, 4'd0, 32'h0, N, 32'h100, 64'h11, L, L, L, 64'h0, L));
    tbl.push_back(V(H, 32'h110, 64'h33, L, 4'd0, 32'h0, N, 32'h100, 64'h11, L, L, L, 64'h0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0, S, 32'h100, 64'h11, L, H, L, 64'h0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0, S, 32'h108, 64'h22, L, L, L, 64'h0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0, S, 32'h110, 64'h33, L, L, L, 64'h0, L));
    tbl.push_back(idle);
    // fill, enqueue with accepted pop while full, then overflow
    tbl.push_back(V(H, 32'h400, 64'h40, L, 4'd0, 32'h0,   N, 32'h0,   64'h0,  H, L, L, 64'h0,  L));
    tbl.push_back(V(H, 32'h408, 64'h41, L, 4'd0, 32'h0,   N, 32'h400, 64'h40, L, L, L, 64'h0,  L));
    tbl.push_back(V(H, 32'h410, 64'h42, L, 4'd0, 32'h0,   N, 32'h400, 64'h40, L, L, L, 64'h0,  L));
    tbl.push_back(V(H, 32'h418, 64'h43, L, 4'd0, 32'h0,   N, 32'h400, 64'h40, L, H, L, 64'h0,  L));
    tbl.push_back(V(H, 32'h420, 64'h44, H, 4'd1, 32'h0,   S, 32'h400, 64'h40, L, H, L, 64'h0,  L));
    tbl.push_back(V(H, 32'h428, 64'h45, L, 4'd0, 32'h0,   N, 32'h408, 64'h41, L, H, L, 64'h0,  H));
    tbl.push_back(V(L, 32'h0,   64'h0,  L, 4'd0, 32'h428, N, 32'h408, 64'h41, L, H, L, 64'h0,  L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h420, S, 32'h408, 64'h41, L, H, H, 64'h44, L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0,   S, 32'h410, 64'h42, L, H, L, 64'h0,  L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0,   S, 32'h418, 64'h43, L, L, L, 64'h0,  L));
    tbl.push_back(V(L, 32'h0,   64'h0,  H, 4'd1, 32'h0,   S, 32'h420, 64'h44, L, L, L, 64'h0,  L));
    tbl.push_back(idle);
    // forwarding: youngest of two same-line entries, then a miss
    tbl.push_back(V(H, 32'h200, 64'hA0A0, L, 4'd0, 32'h0,   N, 32'h0,   64'h0,    H, L, L, 64'h0,    L));
    tbl.push_back(V(H, 32'h200, 64'hB0B0, L, 4'd0, 32'h204, N, 32'h200, 64'hA0A0, L, L, H, 64'hA0A0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,    L, 4'd0, 32'h204, N, 32'h200, 64'hA0A0, L, L, H, 64'hB0B0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,    L, 4'd0, 32'h300, N, 32'h200, 64'hA0A0, L, L, L, 64'h0,    L));
    tbl.push_back(V(L, 32'h0,   64'h0,    H, 4'd1, 32'h200, S, 32'h200, 64'hA0A0, L, L, H, 64'hB0B0, L));
    tbl.push_back(V(L, 32'h0,   64'h0,    H, 4'd1, 32'h200, S, 32'h200, 64'hB0B0, L, L, H, 64'hB0B0, L));
    tbl.push_back(idle);

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // zero response: head retried until a non-zero tag arrives
    run_vec(V(H, 32'h40, 64'h4040, L, 4'd0, 32'h0, N, 32'h0, 64'h0, H, L, L, 64'h0, L), "retry_enq");
    for (int i = 0; i < 3; i++)
      run_vec(V(L, 32'h0, 64'h0, H, 4'd0, 32'h0, S, 32'h40, 64'h4040, L, L, L, 64'h0, L), $sformatf("retry%0d", i));
    run_vec(V(L, 32'h0, 64'h0, H, 4'd5, 32'h0, S, 32'h40, 64'h4040, L, L, L, 64'h0, L), "retry_pop");
    run_vec(idle, "retry_done");

    // same line twice behind a different head: coalesces only with the macro
    run_vec(V(H, 32'h80, 64'h1, L, 4'd0, 32'h0, N, 32'h0,  64'h0, H, L, L, 64'h0, L), "coal0");
    run_vec(V(H, 32'h88, 64'h2, L, 4'd0, 32'h0, N, 32'h80, 64'h1, L, L, L, 64'h0, L), "coal1");
    run_vec(V(H, 32'h88, 64'h3, L, 4'd0, 32'h0, N, 32'h80, 64'h1, L, L, L, 64'h0, L), "coal2");
    run_vec(V(L, 32'h0,  64'h0, L, 4'd0, 32'h88, N, 32'h80, 64'h1, L, COALESCE ? L : H, H, 64'h3, L), "coal_fwd");
    run_vec(V(L, 32'h0,  64'h0, H, 4'd1, 32'h0, S, 32'h80, 64'h1, L, COALESCE ? L : H, L, 64'h0, L), "coal_d0");
    run_vec(V(L, 32'h0,  64'h0, H, 4'd1, 32'h0, S, 32'h88, COALESCE ? 64'h3 : 64'h2, L, L, L, 64'h0, L), "coal_d1");
    if (COALESCE)
      run_vec(V(L, 32'h0, 64'h0, H, 4'd1, 32'h0, N, 32'h0, 64'h0, H, L, L, 64'h0, L), "coal_d2");
    else
      run_vec(V(L, 32'h0, 64'h0, H, 4'd1, 32'h0, S, 32'h88, 64'h3, L, L, L, 64'h0, L), "coal_d2");
    run_vec(idle, "coal_done");

    // reset while entries are queued discards them
    run_vec(V(H, 32'h500, 64'h55, L, 4'd0, 32'h0, N, 32'h0,   64'h0,  H, L, L, 64'h0, L), "mid0");
    run_vec(V(H, 32'h508, 64'h56, L, 4'd0, 32'h0, N, 32'h500, 64'h55, L, L, L, 64'h0, L), "mid1");
    do_reset();
    run_vec(V(L, 32'h0, 64'h0, L, 4'd0, 32'h500, N, 32'h0, 64'h0, H, L, L, 64'h0, L), "mid_reset");

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rs.ev  = ($urandom_range(0, 99) < 50);
      rs.ea  = 32'h800 + 32'(8 * $urandom_range(0, 5));
      rs.ed  = {$urandom, $urandom};
      rs.gr  = ($urandom_range(0, 99) < 65);
      rs.rsp = 4'($urandom_range(0, 3));
      rs.la  = 32'h800 + 32'(8 * $urandom_range(0, 6)) + 32'($urandom_range(0, 7));
      run_cycle(rs, dummy, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
